// File: rtl/kf_meas_feeder.sv
// Measurement feeder for kf_top: two's-complement to sign-magnitude conversion, sample FIFO,
// one-iteration-per-sample launch FSM and watchdog. Define KF_FEED_STATS_EN for iter/sat counters.
module kf_meas_feeder #(
    parameter int unsigned W       = 24,
    parameter int unsigned FRAC    = 14,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [W-1:0]             s_data,
    output logic                     s_ready,
    input  logic                     kf_ready,
    input  logic                     kf_au_done,
    input  logic [W-1:0]             kf_result,
    output logic                     kf_start,
    output logic [W-1:0]             kf_data,
    output logic                     r_valid,
    output logic [W-1:0]             r_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     sat_seen,
    output logic [15:0]              iter_count,
    output logic [15:0]              sat_count
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    if ((DEPTH < 2) || ((1 << AW) != DEPTH) || (FRAC >= W)) begin : g_bad_cfg
        $error("kf_meas_feeder: DEPTH must be a power of two >= 2 and FRAC < W");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic [WDW-1:0] wd;
    logic [W-1:0]   neg_val, conv;
    logic           push, pop, full, empty, sat, done_evt, wd_expire;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign s_ready    = !full;
    assign push       = s_valid && s_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE);
    assign kf_start   = (state == LAUNCH);

    // -2^(W-1) has no sign-magnitude counterpart; clamp to the largest negative magnitude.
    always_comb begin
        neg_val = '0 - s_data;
        sat     = (s_data == MOST_NEG);
        if (sat)
            conv = '1;
        else if (s_data[W-1])
            conv = {1'b1, neg_val[W-2:0]};
        else
            conv = {1'b0, s_data[W-2:0]};
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        done_evt  = 1'b0;
        wd_expire = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && kf_ready) begin
                    pop      = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: state_nx = RUN;
            RUN: begin
                if (kf_au_done) begin
                    done_evt = 1'b1;
                    state_nx = IDLE;
                end else if (wd == WDW'(TIMEOUT)) begin
                    wd_expire = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= conv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kf_data     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
            sat_seen    <= 1'b0;
        end else begin
            r_valid <= done_evt;
            if (pop)      kf_data <= mem[rptr];
            if (done_evt) r_data  <= kf_result;
            if (state == LAUNCH)   wd <= '0;
            else if (state == RUN) wd <= wd + WDW'(1);
            if (wd_expire)    timeout_err <= 1'b1;
            if (push && sat)  sat_seen    <= 1'b1;
        end
    end

`ifdef KF_FEED_STATS_EN
    logic [15:0] iter_q, sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
            sat_q  <= '0;
        end else begin
            if (done_evt)    iter_q <= iter_q + 16'd1;
            if (push && sat) sat_q  <= sat_q + 16'd1;
        end
    end

    assign iter_count = iter_q;
    assign sat_count  = sat_q;
`else
    assign iter_count = '0;
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_kf_meas_feeder.sv
// Directed self-checking bench for kf_meas_feeder; kf_top handshake is driven by hand.
module tb_kf_meas_feeder;
    localparam int unsigned W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         kf_ready;
    logic         kf_au_done;
    logic [W-1:0] kf_result;
    logic         kf_start;
    logic [W-1:0] kf_data;
    logic         r_valid;
    logic [W-1:0] r_data;
    logic [3:0]   fifo_count;
    logic         busy;
    logic         timeout_err;
    logic         sat_seen;
    logic [15:0]  iter_count;
    logic [15:0]  sat_count;

    int checks = 0;
    int errors = 0;
    int exp_iter = 0;
    int exp_sat = 0;

    always #5 clk = ~clk;

    kf_meas_feeder #(.W(24), .FRAC(14), .DEPTH(8), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .kf_ready(kf_ready), .kf_au_done(kf_au_done), .kf_result(kf_result),
        .kf_start(kf_start), .kf_data(kf_data), .r_valid(r_valid), .r_data(r_data),
        .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err),
        .sat_seen(sat_seen), .iter_count(iter_count), .sat_count(sat_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int v);
`ifdef KF_FEED_STATS_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic push(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Waits (bounded) for the launch pulse and checks the converted word.
    task automatic wait_start(input string tag, input logic [W-1:0] exp);
        int n = 0;
        while (!kf_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_start"}, 32'(kf_start), 32'd1);
        check_eq({tag, "_data"}, 32'(kf_data), 32'(exp));
    endtask

    // Called in the LAUNCH cycle: confirms a single start pulse, then finishes the iteration.
    task automatic complete(input string tag, input logic [W-1:0] res);
        @(negedge clk);
        check_eq({tag, "_start_once"}, 32'(kf_start), 32'd0);
        kf_au_done = 1'b1;
        kf_result  = res;
        @(negedge clk);
        kf_au_done = 1'b0;
        exp_iter++;
        check_eq({tag, "_rvalid"}, 32'(r_valid), 32'd1);
        check_eq({tag, "_rdata"}, 32'(r_data), 32'(res));
        @(negedge clk);
        check_eq({tag, "_rvalid_drop"}, 32'(r_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] vec [9];
        int           cyc;
        bit           rv_seen;

        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        kf_ready = 1'b0; kf_au_done = 1'b0; kf_result = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_kf_start", 32'(kf_start), 32'd0);
        check_eq("rst_kf_data", 32'(kf_data), 32'd0);
        check_eq("rst_r_valid", 32'(r_valid), 32'd0);
        check_eq("rst_r_data", 32'(r_data), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_flags", {30'd0, timeout_err, sat_seen}, 32'd0);
        check_eq("rst_stats", {iter_count, sat_count}, 32'd0);

        // Basic launch: 1.5 in Q10.14, exact latency.
        kf_ready = 1'b1;
        push(24'h006000);
        check_eq("t1_count", 32'(fifo_count), 32'd1);
        check_eq("t1_no_early_start", 32'(kf_start), 32'd0);
        @(negedge clk);
        check_eq("t1_start", 32'(kf_start), 32'd1);
        check_eq("t1_kf_data", 32'(kf_data), 32'h006000);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_popped", 32'(fifo_count), 32'd0);
        complete("t1", 24'h004200);
        check_eq("t1_iter", 32'(iter_count), stat_exp(exp_iter));
        check_eq("t1_kf_data_hold", 32'(kf_data), 32'h006000);
        check_eq("t1_idle", 32'(busy), 32'd0);

        // au_done outside RUN has no effect.
        kf_au_done = 1'b1; kf_result = 24'h00ABCD;
        @(negedge clk);
        kf_au_done = 1'b0;
        check_eq("stray_done_rvalid", 32'(r_valid), 32'd0);
        check_eq("stray_done_rdata", 32'(r_data), 32'h004200);

        // Negative and saturating conversions.
        push(24'hFFE000);
        wait_start("neg", 24'h802000);
        complete("neg", 24'h000123);
        check_eq("neg_no_sat", 32'(sat_seen), 32'd0);
        push(24'h7FFFFF);
        wait_start("maxpos", 24'h7FFFFF);
        complete("maxpos", 24'h000001);
        push(24'h800000);
        exp_sat++;
        wait_start("sat", 24'hFFFFFF);
        check_eq("sat_seen", 32'(sat_seen), 32'd1);
        check_eq("sat_count", 32'(sat_count), stat_exp(exp_sat));
        complete("sat", 24'h000002);
        check_eq("iter_after_sat", 32'(iter_count), stat_exp(exp_iter));

        // Fill: 9 offered while kf_top is not ready, only 8 fit.
        kf_ready = 1'b0;
        for (int i = 0; i < 9; i++) vec[i] = 24'(32'h000100 * (i + 1));
        for (int i = 0; i < 9; i++) push(vec[i]);
        check_eq("full_count", 32'(fifo_count), 32'd8);
        check_eq("full_s_ready", 32'(s_ready), 32'd0);
        check_eq("full_idle", 32'(busy), 32'd0);
        kf_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_start($sformatf("fifo%0d", i), vec[i]);
            complete($sformatf("fifo%0d", i), vec[i] ^ 24'h000FFF);
        end
        repeat (3) @(negedge clk);
        check_eq("drain_count", 32'(fifo_count), 32'd0);
        check_eq("drain_idle", 32'(busy), 32'd0);
        check_eq("drain_iter", 32'(iter_count), stat_exp(exp_iter));

        // Watchdog: never answer.
        push(24'h000400);
        wait_start("wd", 24'h000400);
        cyc = 0; rv_seen = 1'b0;
        while (busy && cyc < 1100) begin
            @(negedge clk);
            cyc++;
            if (r_valid) rv_seen = 1'b1;
        end
        check_eq("wd_back_idle", 32'(busy), 32'd0);
        check_eq("wd_window", 32'(cyc >= 1024 && cyc <= 1027), 32'd1);
        check_eq("wd_err", 32'(timeout_err), 32'd1);
        check_eq("wd_no_rvalid", 32'(rv_seen), 32'd0);
        check_eq("wd_iter", 32'(iter_count), stat_exp(exp_iter));
        push(24'h001000);
        wait_start("post_wd", 24'h001000);
        complete("post_wd", 24'h003300);
        check_eq("wd_err_sticky", 32'(timeout_err), 32'd1);

        // Reset in RUN with three samples queued.
        push(24'h000011);
        wait_start("rstrun", 24'h000011);
        @(negedge clk);
        push(24'h000022);
        push(24'h000033);
        push(24'h000044);
        check_eq("rstrun_queued", 32'(fifo_count), 32'd3);
        check_eq("rstrun_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstrun_busy", 32'(busy), 32'd0);
        check_eq("rstrun_count", 32'(fifo_count), 32'd0);
        check_eq("rstrun_start", 32'(kf_start), 32'd0);
        check_eq("rstrun_err_clr", 32'(timeout_err), 32'd0);
        rv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (kf_start) rv_seen = 1'b1;
        end
        check_eq("rstrun_no_launch", 32'(rv_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
